// File: rtl/minibus_uart_tx_if.sv
// minibus request/response bundle between the decoder and a slave.
// Requests are one-cycle pulses; the slave answers exactly one cycle later.
interface minibus_uart_tx_if;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [31:0] res_rdata;
  logic        res_ready;
  logic        res_error;

  modport master (
    output req_addr, req_ren, req_wen, req_wdata,
    input  res_rdata, res_ready, res_error
  );

  modport slave (
    input  req_addr, req_ren, req_wen, req_wdata,
    output res_rdata, res_ready, res_error
  );
endinterface

// File: rtl/minibus_uart_tx.sv
// minibus_uart_tx: minibus slave with a TX FIFO feeding an 8N1 serialiser.
// Offsets: 0 DATA, 1 STATUS, 2 DIV, 3 unmapped (error response).
module minibus_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 434,
  parameter int DIV_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  minibus_uart_tx_if.slave bus,
  output logic             tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q;
  logic [7:0]           shift_q;
  logic [DIV_WIDTH-1:0] fdiv_q;
  logic [DIV_WIDTH-1:0] baud_q;
  logic [2:0]           bit_q;
  logic                 tx_q;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 res_ready_q, res_ready_d;
  logic                 res_error_q, res_error_d;
  logic [31:0]          res_rdata_q, res_rdata_d;

  logic                 wr, rd, req;
  logic                 sel_data, sel_stat, sel_div, sel_bad;
  logic                 full, empty, busy;
  logic                 push, push_ok, pop;
  logic [DIV_WIDTH-1:0] wdiv;
  logic [31:0]          status;
  logic                 unused_ok;

  assign wr  = bus.req_wen;
  assign rd  = bus.req_ren & ~bus.req_wen;
  assign req = bus.req_ren | bus.req_wen;

  assign sel_data = bus.req_addr[3:2] == 2'd0;
  assign sel_stat = bus.req_addr[3:2] == 2'd1;
  assign sel_div  = bus.req_addr[3:2] == 2'd2;
  assign sel_bad  = bus.req_addr[3:2] == 2'd3;

  assign full  = count_q == CW'(FIFO_DEPTH);
  assign empty = count_q == '0;
  assign busy  = state_q != IDLE;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop     = (state_q == IDLE) && !empty;
  assign push    = wr && sel_data;
  assign push_ok = push && (!full || pop);

  assign wdiv   = bus.req_wdata[DIV_WIDTH-1:0];
  assign status = {16'd0, 8'(count_q), 4'd0, ovf_q, busy, empty, full};

  always_comb begin
    wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q;
    if (rd && sel_stat) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
    div_d = div_q;
    if (wr && sel_div) div_d = (wdiv < TWO) ? TWO : wdiv;
  end

  always_comb begin
    res_ready_d = req;
    res_error_d = req && sel_bad;
    res_rdata_d = '0;
    if (rd) begin
      unique case (1'b1)
        sel_stat: res_rdata_d = status;
        sel_div:  res_rdata_d = 32'(div_q);
        default:  res_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      div_q       <= DIV_WIDTH'(DIV_RESET);
      res_ready_q <= 1'b0;
      res_error_q <= 1'b0;
      res_rdata_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
      res_ready_q <= res_ready_d;
      res_error_q <= res_error_d;
      res_rdata_q <= res_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= bus.req_wdata[7:0];
  end

  // Each bit lasts fdiv clocks: baud loads fdiv-1 on entry, moves on at 0.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      shift_q <= '0;
      fdiv_q  <= DIV_WIDTH'(DIV_RESET);
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            fdiv_q  <= div_q;
            baud_q  <= div_q - ONE;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_q == '0) begin
            baud_q  <= fdiv_q - ONE;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - ONE;
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q <= fdiv_q - ONE;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q - ONE;
          end
        end
        STOP: begin
          if (baud_q == '0) state_q <= IDLE;
          else baud_q <= baud_q - ONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx            = tx_q;
  assign bus.res_ready = res_ready_q;
  assign bus.res_error = res_error_q;
  assign bus.res_rdata = res_rdata_q;

  assign unused_ok = ^{bus.req_addr, bus.req_wdata};
endmodule

// File: tb/tb_minibus_uart_tx.sv
// Bench for minibus_uart_tx: bus and serial scoreboards, one task per scenario.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_minibus_uart_tx;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic tx;

  minibus_uart_tx_if bus();

  minibus_uart_tx #(
    .FIFO_DEPTH(8),
    .DIV_RESET (434),
    .DIV_WIDTH (16)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [32:0] bexp_q[$];
  logic [32:0] bobs_q[$];
  logic [8:0]  rx_q[$];
  logic [7:0]  txexp_q[$];

  int   mon_div = 4;
  bit   mon_en  = 1'b0;
  int   m_cnt   = -1;
  int   m_div   = 4;
  logic [7:0] m_byte;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_DIV  = 32'h8;
  localparam logic [31:0] A_BAD  = 32'hC;

  // bus response monitor
  always @(negedge clk) begin
    if (bus.res_ready === 1'b1)
      bobs_q.push_back({bus.res_error, bus.res_rdata});
  end

  // serial receiver: samples each bit in its middle
  always @(negedge clk) begin
    if (!mon_en) begin
      m_cnt = -1;
    end else if (m_cnt < 0) begin
      if (tx === 1'b0) begin
        m_cnt = 1;
        m_div = mon_div;
      end
    end else begin
      for (int k = 1; k <= 8; k++)
        if (m_cnt == k * m_div + m_div / 2) m_byte[k-1] = tx;
      if (m_cnt == 9 * m_div + m_div / 2) begin
        rx_q.push_back({tx, m_byte});
        m_cnt = -1;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic bus_cyc(input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_wen   = w;
    bus.req_ren   = r;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    bus.req_wen = 1'b0;
    bus.req_ren = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    bus.req_wen = 1'b0;
    bus.req_ren = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    bobs_q.delete();
    bexp_q.delete();
  endtask

  task automatic test_reset();
    logic [32:0] e, o;
    bus.req_wen = 1'b0;
    bus.req_ren = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (tx !== 1'b1 || bus.res_ready !== 1'b0 || bus.res_error !== 1'b0
        || bus.res_rdata !== 32'h0)
      $display("FAIL reset_outputs: got tx=%b rdy=%b err=%b rd=%h want 1 0 0 0",
               tx, bus.res_ready, bus.res_error, bus.res_rdata);
    else n_pass++;
    nrst = 1'b1;
    bexp_q.push_back({1'b0, 32'h2});
    bus_cyc(1'b0, 1'b1, A_STAT, '0);
    bexp_q.push_back({1'b0, 32'd434});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    repeat (2) @(negedge clk);
    #1;
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL reset_read: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
    n_chk++;
    if (bobs_q.size() != 0)
      $display("FAIL reset_extra_resp: got %0d extra want 0", bobs_q.size());
    else n_pass++;
  endtask

  task automatic test_single_byte();
    logic [32:0] e, o;
    logic [8:0]  r;
    logic [7:0]  b;
    logic        exp_tx;
    int          found, bad;
    mon_div = 4;
    mon_en = 1'b1;
    rx_q.delete();
    b = 8'hA5;
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd4);
    bexp_q.push_back({1'b0, 32'h0});
    txexp_q.push_back(b);
    bus_cyc(1'b1, 1'b0, A_DATA, {24'd0, b});
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
    end
    n_chk++;
    if (found == 0) $display("FAIL byte_start: got no start bit want start");
    else n_pass++;
    bad = 0;
    for (int c = 0; c <= 41; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        bus.req_ren  = 1'b1;
        bus.req_addr = A_STAT;
        for (int k = 0; k < 40; k++) bexp_q.push_back({1'b0, 32'h6});
        bexp_q.push_back({1'b0, 32'h2});
      end
      if (c == 41) bus.req_ren = 1'b0;
      if (c <= 40) begin
        if (c < 4) exp_tx = 1'b0;
        else if (c < 36) exp_tx = b[(c-4)/4];
        else exp_tx = 1'b1;
        if (tx !== exp_tx) begin
          if (bad == 0)
            $display("FAIL byte_wave: clock %0d got tx=%b want %b", c, tx, exp_tx);
          bad++;
        end
      end
    end
    n_chk++;
    if (bad == 0) n_pass++;
    #1;
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL byte_status: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
    n_chk++;
    if (rx_q.size() == 0 || txexp_q.size() == 0) begin
      $display("FAIL byte_rx: got %0d frames want 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      b = txexp_q.pop_front();
      if (r !== {1'b1, b})
        $display("FAIL byte_rx: got stop=%b data=%h want stop=1 data=%h", r[8], r[7:0], b);
      else n_pass++;
    end
    mon_en = 1'b0;
    txexp_q.delete();
  endtask

  task automatic test_overflow();
    logic [32:0] e, o;
    mon_en = 1'b0;
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd1000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_wen   = 1'b1;
      bus.req_addr  = A_DATA;
      bus.req_wdata = 32'h30 + 32'(i);
      bexp_q.push_back({1'b0, 32'h0});
    end
    @(negedge clk);
    bus.req_wen = 1'b0;
    #1;
    bexp_q.push_back({1'b0, 32'h0000_080D});
    bus_cyc(1'b0, 1'b1, A_STAT, '0);
    bexp_q.push_back({1'b0, 32'h0000_0805});
    bus_cyc(1'b0, 1'b1, A_STAT, '0);
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL overflow: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_div_change();
    logic [32:0] e, o;
    logic [8:0]  r;
    logic [7:0]  b;
    int          waited;
    mon_div = 4;
    rx_q.delete();
    txexp_q.delete();
    mon_en = 1'b1;
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd4);
    bexp_q.push_back({1'b0, 32'h0});
    txexp_q.push_back(8'h01);
    bus_cyc(1'b1, 1'b0, A_DATA, 32'h01);
    repeat (12) @(negedge clk);
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd8);
    mon_div = 8;
    bexp_q.push_back({1'b0, 32'h0});
    txexp_q.push_back(8'h02);
    bus_cyc(1'b1, 1'b0, A_DATA, 32'h02);
    bexp_q.push_back({1'b0, 32'd8});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    waited = 0;
    while (rx_q.size() < 2 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx_q.size() == 0 || txexp_q.size() == 0) begin
        $display("FAIL div_frame%0d: got no frame want one", i);
      end else begin
        r = rx_q.pop_front();
        b = txexp_q.pop_front();
        if (r !== {1'b1, b})
          $display("FAIL div_frame%0d: got stop=%b data=%h want stop=1 data=%h",
                   i, r[8], r[7:0], b);
        else n_pass++;
      end
    end
    mon_en = 1'b0;
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd1);
    bexp_q.push_back({1'b0, 32'd2});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd0);
    bexp_q.push_back({1'b0, 32'd2});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL div_bus: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] e, o;
    int          bad;
    mon_en = 1'b0;
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b0, A_DIV, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_wen   = 1'b1;
      bus.req_addr  = A_DATA;
      bus.req_wdata = (i == 0) ? 32'h00 : 32'h55;
      bexp_q.push_back({1'b0, 32'h0});
    end
    @(negedge clk);
    bus.req_wen = 1'b0;
    #1;
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL mid_writes: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
    repeat (14) @(negedge clk);
    n_chk++;
    if (tx !== 1'b0) $display("FAIL mid_in_frame: got tx=%b want 0", tx);
    else n_pass++;
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tx !== 1'b1) $display("FAIL mid_tx_idle: got tx=%b want 1", tx);
    else n_pass++;
    nrst = 1'b1;
    #1;
    bobs_q.delete();
    bexp_q.push_back({1'b0, 32'h2});
    bus_cyc(1'b0, 1'b1, A_STAT, '0);
    e = bexp_q.pop_front();
    o = 'x;
    if (bobs_q.size() > 0) o = bobs_q.pop_front();
    n_chk++;
    if (o !== e)
      $display("FAIL mid_status: got err=%b data=%h want err=%b data=%h",
               o[32], o[31:0], e[32], e[31:0]);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL mid_no_frames: got %0d low clocks want 0", bad);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [32:0] e, o;
    bexp_q.push_back({1'b1, 32'h0});
    bus_cyc(1'b0, 1'b1, A_BAD, '0);
    bexp_q.push_back({1'b1, 32'h0});
    bus_cyc(1'b1, 1'b0, A_BAD, 32'hFFFF_FFFF);
    bexp_q.push_back({1'b0, 32'd434});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    bexp_q.push_back({1'b0, 32'h2});
    bus_cyc(1'b0, 1'b1, A_STAT, '0);
    bexp_q.push_back({1'b0, 32'h0});
    bus_cyc(1'b1, 1'b1, A_DIV, 32'd6);
    bexp_q.push_back({1'b0, 32'd6});
    bus_cyc(1'b0, 1'b1, A_DIV, '0);
    while (bexp_q.size() > 0) begin
      e = bexp_q.pop_front();
      o = 'x;
      if (bobs_q.size() > 0) o = bobs_q.pop_front();
      n_chk++;
      if (o !== e)
        $display("FAIL unmapped: got err=%b data=%h want err=%b data=%h",
                 o[32], o[31:0], e[32], e[31:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_div_change();
    test_reset_mid();
    test_unmapped();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
